battle_turn_sched: RTL
======================

// Module: battle_turn_sched
// PURPOSE
//  Turn scheduler for the battle datapath. It sequences one player attack, then one AI attack, per
//  `go` rising edge, and rolls accuracy from an internal LFSR. It applies saturating damage to the
//  5-bit HP registers and holds each result for a display window. It flags victory or loss.
//  Sits between the board switches/KEYs and the HEX/LED display drivers at top level.
// PARAMETERS
//  MAX_HP       20          starting HP for both trainers (<=31)
//  DISP_CYCLES  50_000_000  cycles each attack result is held (SHOW states); >=1
//  LFSR_SEED    16'hACE1    LFSR reset value; must be nonzero
//  FORCE_HIT    0           1: every roll hits (bench/debug)
//  AI_MOVE_SEL  4           0..3: AI always uses that move; 4: AI move = lfsr[5:4]
// PORTS
//  clk             in   1  system clock (CLOCK_50)
//  rst             in   1  synchronous reset, active-high
//  go              in   1  level input (switch); a rising edge starts a turn
//  p_move          in   2  player move select; sampled only on the go-edge cycle
//  p_hp            out  5  player HP
//  ai_hp           out  5  AI HP
//  dmg             out  5  damage of the move in progress/last shown
//  accu            out  5  accuracy (x/16) of the move in progress/last shown
//  hit             out  1  result of the last roll
//  active_trainer  out  1  0 = player attacking/idle, 1 = AI attacking
//  apply_damage    out  1  one-cycle pulse in the APPLY states
//  target          out  1  1 = damage targets AI, 0 = targets player
//  victory         out  1  sticky; high in WIN
//  loss            out  1  sticky; high in LOSE
//  state           out  4  encoded FSM state (for LEDR debug)
// BEHAVIOUR
//  - Reset: p_hp=ai_hp=MAX_HP; all other outputs 0; state=IDLE; lfsr=LFSR_SEED; go_q=0; counter=0.
//  - go edge = go & ~go_q (go_q registered each cycle). Edges outside IDLE are ignored, not queued.
//  - LFSR: 16-bit Galois, taps 16'hB400; advances every cycle except in reset.
//  - Move table (dmg, accu): 0:(4,15) 1:(6,12) 2:(9,8) 3:(12,5).
//  - Roll: hit = FORCE_HIT | (lfsr[3:0] < accu).
//  - FSM states and transitions:
//    IDLE(0): on go edge, latch dmg/accu from p_move; go to P_ROLL.
//    P_ROLL(1): register hit; go to P_APPLY.
//    P_APPLY(2): apply_damage=1, target=1; if hit, ai_hp <= ai_hp>dmg ? ai_hp-dmg : 0; go to P_SHOW.
//    P_SHOW(3): count DISP_CYCLES, then go to WIN if ai_hp==0, else AI_ROLL.
//    AI_ROLL(4): active_trainer=1; latch the AI move's dmg/accu; register hit.
//    AI_APPLY(5): apply_damage=1, target=0; saturating subtract from p_hp.
//    AI_SHOW(6): count DISP_CYCLES, then go to LOSE if p_hp==0, else IDLE.
//    IDLE clears active_trainer.
//  - Timing: edge seen in cycle n -> P_ROLL n+1 -> apply_damage high n+2 -> new HP visible n+3.
//  - WIN(7)/LOSE(8): terminal until rst; go ignored; HP frozen.
//  - HP never wraps; dmg >= hp always yields 0.
//  - The player's move 3 at 20 HP leaves 8; no underflow path exists.
//  - Reset mid-operation (any state, including mid-count) wins over every transition. Reset values
//    appear in the next cycle.
// STRUCTURE
//  - pbs_pkg: state localparams, move-table constants (MOVE_DMG[4], MOVE_ACCU[4]), HP_W=5,
//    sat_sub function.
//  - One sub-module, pbs_lfsr (SEED parameter; clk, rst, q[15:0]). FSM, counter and HP registers
//    stay in this block.
// TESTING  (MAX_HP=20, DISP_CYCLES=4, FORCE_HIT=1, AI_MOVE_SEL=0 unless stated)
//  1. Assert rst for 2 cycles -> p_hp=ai_hp=20, state=0, all flags 0; outputs stay so with go=0.
//  2. p_move=3, raise go -> apply_damage pulse at edge+2 with target=1; ai_hp=8 at edge+3.
//     AI move 0 follows -> p_hp=16; state returns to 0.
//  3. From (16,8), p_move=3, go edge -> ai_hp=0; victory=1 after P_SHOW; p_hp stays 16.
//     Further go edges do nothing.
//  4. AI_MOVE_SEL=3, p_move=0, two go edges -> p_hp 20->8->0; ai_hp 16->12; loss=1; state=8.
//  5. Hold go high across a full turn; toggle go during P_SHOW -> exactly one turn executes.
//  6. Assert rst during AI_SHOW, mid-count -> next cycle all reset values. FORCE_HIT=0 with the
//     default seed: the hit sequence matches the bench LFSR model.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle turn scheduler: FSM encoding, move table, HP helpers.
package pbs_pkg;

  localparam int HP_W = 5;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_P_ROLL   = 4'd1,
    S_P_APPLY  = 4'd2,
    S_P_SHOW   = 4'd3,
    S_AI_ROLL  = 4'd4,
    S_AI_APPLY = 4'd5,
    S_AI_SHOW  = 4'd6,
    S_WIN      = 4'd7,
    S_LOSE     = 4'd8
  } state_t;

  // Index is the 2-bit move select; accuracy is out of 16.
  localparam logic [HP_W-1:0] MOVE_DMG  [4] = '{5'd4,  5'd6,  5'd9, 5'd12};
  localparam logic [HP_W-1:0] MOVE_ACCU [4] = '{5'd15, 5'd12, 5'd8, 5'd5};

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/pbs_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400) feeding the accuracy and AI move rolls.
module pbs_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/battle_turn_sched.sv
// Turn scheduler: one player attack then one AI attack per go edge, with saturating HP updates,
// a display hold after each attack, and terminal WIN/LOSE states.
module battle_turn_sched
  import pbs_pkg::*;
#(
  parameter int          MAX_HP      = 20,
  parameter int          DISP_CYCLES = 50_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          FORCE_HIT   = 1'b0,
  parameter int          AI_MOVE_SEL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [1:0]      p_move,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [HP_W-1:0] dmg,
  output logic [HP_W-1:0] accu,
  output logic            hit,
  output logic            active_trainer,
  output logic            apply_damage,
  output logic            target,
  output logic            victory,
  output logic            loss,
  output logic [3:0]      state
);

  localparam int              CNT_W    = $clog2(DISP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISP_CYCLES - 1);
  localparam logic [HP_W-1:0]  HP_INIT  = HP_W'(MAX_HP);

  state_t           cur, nxt;
  logic             go_q, go_edge, cnt_done, roll_hit;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      lfsr;
  logic [9:0]       unused_lfsr;
  logic [1:0]       ai_move;
  logic [HP_W-1:0]  roll_accu;

  pbs_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Only the low six bits drive the rolls.
  assign unused_lfsr = lfsr[15:6];

  assign go_edge   = go & ~go_q;
  assign cnt_done  = (cnt == CNT_LAST);
  assign ai_move   = (AI_MOVE_SEL < 4) ? 2'(AI_MOVE_SEL) : lfsr[5:4];
  assign roll_accu = (cur == S_AI_ROLL) ? MOVE_ACCU[ai_move] : accu;
  assign roll_hit  = FORCE_HIT | ({1'b0, lfsr[3:0]} < roll_accu);

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:     if (go_edge) nxt = S_P_ROLL;
      S_P_ROLL:   nxt = S_P_APPLY;
      S_P_APPLY:  nxt = S_P_SHOW;
      S_P_SHOW:   if (cnt_done) nxt = (ai_hp == '0) ? S_WIN : S_AI_ROLL;
      S_AI_ROLL:  nxt = S_AI_APPLY;
      S_AI_APPLY: nxt = S_AI_SHOW;
      S_AI_SHOW:  if (cnt_done) nxt = (p_hp == '0) ? S_LOSE : S_IDLE;
      default:    nxt = cur;
    endcase
  end

  // Attacker flag is set from AI_ROLL onward and only IDLE clears it, so it stays up in LOSE.
  always_comb begin
    apply_damage   = (cur == S_P_APPLY) || (cur == S_AI_APPLY);
    target         = (cur == S_P_APPLY);
    victory        = (cur == S_WIN);
    loss           = (cur == S_LOSE);
    active_trainer = (cur == S_AI_ROLL) || (cur == S_AI_APPLY) ||
                     (cur == S_AI_SHOW) || (cur == S_LOSE);
    state          = cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      go_q  <= 1'b0;
      cnt   <= '0;
      p_hp  <= HP_INIT;
      ai_hp <= HP_INIT;
      dmg   <= '0;
      accu  <= '0;
      hit   <= 1'b0;
    end else begin
      go_q <= go;
      cnt  <= ((cur == S_P_SHOW || cur == S_AI_SHOW) && !cnt_done) ? cnt + 1'b1 : '0;
      case (cur)
        S_IDLE: if (go_edge) begin
          dmg  <= MOVE_DMG[p_move];
          accu <= MOVE_ACCU[p_move];
        end
        S_P_ROLL:   hit <= roll_hit;
        S_P_APPLY:  if (hit) ai_hp <= sat_sub(ai_hp, dmg);
        S_AI_ROLL: begin
          dmg  <= MOVE_DMG[ai_move];
          accu <= MOVE_ACCU[ai_move];
          hit  <= roll_hit;
        end
        S_AI_APPLY: if (hit) p_hp <= sat_sub(p_hp, dmg);
        default: ;
      endcase
    end
  end

endmodule
